// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell plus a carry flip-flop, LSB first.
// Latency: done pulses WIDTH+1 edges after the accepted start edge.
// Backpressure: none; start is only sampled in IDLE and ignored otherwise.

// Single-bit full adder cell used by the serial datapath.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_s;
  logic fa_c;

  full_adder u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE waits for start, RUN lasts WIDTH edges, DONE one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: capture on start, shift one bit per RUN edge,
  // and load the visible result registers on the final RUN edge.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // On the MSB edge carry_q is the carry into the MSB and fa_c the
          // carry out of it; their XOR is the signed overflow.
          sum_d  = {fa_s, res_q[WIDTH-1:1]};
          cout_d = fa_c;
          ovf_d  = carry_q ^ fa_c;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign sum_out = sum_q;
  assign cout    = cout_q;
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       cin3 = 1'b0;
  logic       busy3, done3, cout3, ovf3;
  logic [2:0] sum3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a_in(a3), .b_in(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum_out(sum3), .cout(cout3), .ovf(ovf3)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One 8-bit operation; optionally disturbs operands and start mid-RUN.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic eco, input logic eov,
                      input bit disturb);
    int lat;
    int bcnt;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    lat = 0;
    bcnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (disturb && n == 3) begin
        a8 = ~a; b8 = 8'h5A; cin8 = ~c; start8 = 1'b1;
      end
      if (disturb && n == 5) start8 = 1'b0;
      if (busy8) bcnt++;
      if (done8) begin
        lat = n;
        break;
      end
    end
    chk("latency8", lat, 9);
    chk("busy_cycles8", bcnt, 8);
    chk("sum8", sum8, es);
    chk("cout8", cout8, eco);
    chk("ovf8", ovf8, eov);
    @(negedge clk);
    chk("done_one_cycle8", done8, 0);
    chk("sum_hold8", sum8, es);
  endtask

  // One 3-bit operation checked against an arithmetic model.
  task automatic run3(input int a, input int b, input int c);
    int lat;
    int tot;
    int sa;
    int sb;
    int ss;
    logic [3:0] exp_cs;
    logic exp_ov;
    @(negedge clk);
    a3 = a[2:0]; b3 = b[2:0]; cin3 = c[0]; start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (done3) begin
        lat = n;
        break;
      end
    end
    tot = a + b + c;
    exp_cs = tot[3:0];
    sa = (a >= 4) ? a - 8 : a;
    sb = (b >= 4) ? b - 8 : b;
    ss = sa + sb + c;
    exp_ov = (ss > 3) || (ss < -4);
    chk("latency3", lat, 4);
    chk("cout_sum3", {cout3, sum3}, exp_cs);
    chk("ovf3", ovf3, exp_ov);
  endtask

  initial begin
    int t[3];
    int k;
    int ndone;
    int nbusy;
    logic [7:0] bb_s[3];
    logic       bb_co[3];
    logic       bb_ov[3];

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'hC8, 8'h9C, 1'b0, 8'h64, 1'b1, 1'b1};

    // Reset state.
    #1;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    chk("rst_ovf", ovf8, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Operands change and start pulses mid-RUN must not affect the result.
    run8(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 7; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].co, vecs[i].ov, 1'b0);
    end

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_rst", busy8, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sum", sum8, 0);
    chk("async_rst_cout", cout8, 0);
    chk("async_rst_ovf", ovf8, 0);
    chk("async_rst_busy", busy8, 0);
    chk("async_rst_done", done8, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("no_done_after_abort", ndone, 0);
    run8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);

    // start held high: three back-to-back operations, period WIDTH+2.
    bb_s[0] = 8'h03; bb_co[0] = 1'b0; bb_ov[0] = 1'b0;
    bb_s[1] = 8'h80; bb_co[1] = 1'b0; bb_ov[1] = 1'b1;
    bb_s[2] = 8'h01; bb_co[2] = 1'b1; bb_ov[2] = 1'b0;
    t[0] = 0; t[1] = 0; t[2] = 0;
    k = 0;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done8) begin
        t[k] = n;
        chk("b2b_sum", sum8, bb_s[k]);
        chk("b2b_cout", cout8, bb_co[k]);
        chk("b2b_ovf", ovf8, bb_ov[k]);
        k++;
        if (k == 1) begin a8 = 8'h40; b8 = 8'h40; end
        if (k == 2) begin a8 = 8'hFE; b8 = 8'h03; end
        if (k == 3) begin
          start8 = 1'b0;
          break;
        end
      end
    end
    start8 = 1'b0;
    chk("b2b_ops", k, 3);
    chk("b2b_first", t[0], 9);
    chk("b2b_period1", t[1] - t[0], 10);
    chk("b2b_period2", t[2] - t[1], 10);
    nbusy = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (busy8) nbusy++;
    end
    chk("b2b_no_extra_op", nbusy, 0);

    // WIDTH=3 exhaustive.
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 2; c++)
          run3(a, b, c);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial adder that consumes the team's full_adder cell: one full_adder instance plus a carry flip-flop adds two WIDTH-bit operands LSB-first, one bit per clock. It sits downstream of operand registers and trades area for latency where a parallel ripple adder is too large. A start/busy/done handshake frames each operation, and the result holds until the next accepted start.

Parameters:
WIDTH, 8, operand/result width in bits (must be >= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a_in  input  WIDTH  operand A, captured on accepted start
b_in  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high while bits are being processed (RUN)
done  output  1  one-cycle pulse: result valid
sum_out  output  WIDTH  registered sum
cout  output  1  registered carry-out of the MSB
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, cout and ovf = 0; sum_out = 0; internal shift registers, carry FF and bit counter = 0. Reset mid-RUN aborts the operation; no done pulse is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE: when start=1 at edge E0, capture a_in/b_in into shift regs A/B, set carry FF to cin, set count=0 and go to RUN (busy=1 after E0). sum_out, cout and ovf keep their previous values until DONE. If start=0, stay in IDLE.
- RUN: each edge computes bit = A[0]^B[0]^carry through the full_adder instance. The sum bit shifts into the result register from the MSB side (right shift). A and B shift right. carry <= adder carry. count++.
- On the edge where count==WIDTH-1, latch the pre-update carry FF value as carry-into-MSB, used for ovf.
- After WIDTH RUN edges (E1..EWIDTH), go to DONE.
- DONE (cycle after EWIDTH): busy=0, done=1, sum_out = result register, cout = final carry, ovf = carry-into-MSB XOR final carry. Next edge returns to IDLE and done=0.
- Latency: done is high exactly WIDTH+1 edges after the start edge. Earliest next start is sampled at EWIDTH+2.
- start is ignored in RUN and DONE; operand inputs may change freely after E0 without effect.
- Result is modulo 2^WIDTH; cout is the unsigned carry. sum_out/cout/ovf are stable from the DONE cycle until the next DONE.
- start held high continuously: operations run back-to-back with one IDLE cycle between them (period WIDTH+2).
- No combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, a=8'h00, b=8'h00, cin=0 -> done 9 cycles after start edge; sum_out=8'h00, cout=0, ovf=0; busy high exactly 8 cycles.
- a=8'hFF, b=8'h01, cin=0 -> sum_out=8'h00, cout=1, ovf=0. Then a=8'h7F, b=8'h01 -> sum_out=8'h80, cout=0, ovf=1.
- a=8'h55, b=8'hAA, cin=1 -> sum_out=8'h00, cout=1, ovf=0. Change a_in/b_in mid-RUN and pulse start -> result unchanged, no restart.
- Reset mid-operation: assert rst_n=0 at cycle 4 of RUN -> outputs 0 immediately (asynchronously), no done. Release reset, start a=8'h10, b=8'h20 -> sum_out=8'h30.
- start held high for 3 operations -> done pulses at period 10 cycles, each result correct.
- WIDTH=3 exhaustive: all 64 a/b pairs x cin in {0,1} compared against a+b+cin -> {cout,sum_out} match; ovf matches the signed check.
